// File: rtl/bch_pkg.sv
// Shared GF(2^6) definitions for the BCH Peterson decoder path: field constants,
// element types, adjugate FSM state codes and the multiply-by-x helper.
package bch_pkg;

    localparam int         GF_M      = 6;
    localparam logic [6:0] PRIM_POLY = 7'b1000011;
    localparam int         WIDTH     = 51;

    typedef logic [GF_M-1:0]  gf_elem_t;
    typedef logic [WIDTH-1:0] wide_elem_t;

    typedef logic [2:0] adj_state_t;
    localparam adj_state_t IDLE = 3'd0;
    localparam adj_state_t LOAD = 3'd1;
    localparam adj_state_t MUL  = 3'd2;
    localparam adj_state_t ACC  = 3'd3;
    localparam adj_state_t DONE = 3'd4;

    // Multiply by x, folding x^6 back in as x+1.
    function automatic gf_elem_t gf_xtime(input gf_elem_t v);
        gf_elem_t r;
        r = {v[GF_M-2:0], 1'b0};
        if (v[GF_M-1]) begin
            r = r ^ PRIM_POLY[GF_M-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mul_serial.sv
// Bit-serial Horner multiplier: wide unreduced polynomial a times field element b,
// reduced mod PRIM_POLY, MSB of a first, one bit per cycle.
module gf_mul_serial
    import bch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  wide_elem_t a,
    input  gf_elem_t   b,
    output gf_elem_t   p,
    output logic       done
);

    gf_elem_t   p_q, p_d;
    wide_elem_t a_q, a_d;
    gf_elem_t   b_q, b_d;
    logic [5:0] k_q, k_d;
    logic       busy_q, busy_d;

    // The start edge only captures operands; the WIDTH Horner steps follow.
    always_comb begin
        p_d    = p_q;
        a_d    = a_q;
        b_d    = b_q;
        k_d    = k_q;
        busy_d = busy_q;
        if (start) begin
            p_d    = '0;
            a_d    = a;
            b_d    = b;
            k_d    = 6'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            p_d = gf_xtime(p_q) ^ (a_q[k_q] ? b_q : '0);
            if (k_q == 6'd0) begin
                busy_d = 1'b0;
            end else begin
                k_d = k_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            busy_q <= busy_d;
        end
    end

    assign p    = p_q;
    assign done = busy_q && (k_q == 6'd0);

endmodule

// File: rtl/bch_adj_syndrome_mul.sv
// Adjugate-times-syndrome stage: lambda_num[i] = XOR_j minor[j][i] * s[j] in GF(2^6),
// one serial multiply per (i, j) pair; the next stage divides by the determinant.
module bch_adj_syndrome_mul
    import bch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0][3:0][WIDTH-1:0] minor_matrix,
    input  logic [3:0][GF_M-1:0]       syndrome_vec,
    input  logic [4:0]                 size,
    input  logic                       start_adj,
    output logic [3:0][GF_M-1:0]       lambda_num,
    output logic                       finished_adj,
    output logic                       size_err
);

    adj_state_t     state_q, state_d;
    logic [1:0]     i_q, i_d, j_q, j_d;
    gf_elem_t [3:0] acc_q, acc_d;
    gf_elem_t [3:0] lambda_q, lambda_d;
    logic           finished_q, finished_d;
    logic           size_err_q, size_err_d;
    logic           mul_start, mul_done;
    gf_elem_t       mul_p;
    logic           bad_size;
    logic [1:0]     last_idx;

    assign bad_size = (size != 5'd2) && (size != 5'd3);
    assign last_idx = size[1:0] - 2'd1;
    assign mul_start = (state_q == LOAD) && start_adj;

    // Transpose by indexing: row j of the minor feeds output column i.
    gf_mul_serial u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (minor_matrix[j_q][i_q]),
        .b     (syndrome_vec[j_q]),
        .p     (mul_p),
        .done  (mul_done)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        acc_d      = acc_q;
        lambda_d   = lambda_q;
        finished_d = finished_q;
        size_err_d = size_err_q;
        case (state_q)
            IDLE: begin
                if (start_adj && !finished_q) begin
                    acc_d   = '0;
                    i_d     = 2'd0;
                    j_d     = 2'd0;
                    state_d = bad_size ? DONE : LOAD;
                end
            end
            LOAD: state_d = start_adj ? MUL : IDLE;
            MUL: begin
                if (!start_adj) begin
                    state_d = IDLE;
                end else if (mul_done) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (!start_adj) begin
                    state_d = IDLE;
                end else begin
                    acc_d[i_q] = acc_q[i_q] ^ mul_p;
                    if (j_q != last_idx) begin
                        j_d = j_q + 2'd1;
                    end else begin
                        j_d = 2'd0;
                        i_d = i_q + 2'd1;
                    end
                    state_d = ((i_q == last_idx) && (j_q == last_idx)) ? DONE : LOAD;
                end
            end
            DONE: begin
                // Publish once on entry; a dropped request retires the result flag.
                if (!start_adj) begin
                    state_d    = IDLE;
                    finished_d = 1'b0;
                    size_err_d = 1'b0;
                end else if (!finished_q) begin
                    lambda_d   = acc_q;
                    finished_d = 1'b1;
                    size_err_d = bad_size;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            acc_q      <= '0;
            lambda_q   <= '0;
            finished_q <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            acc_q      <= acc_d;
            lambda_q   <= lambda_d;
            finished_q <= finished_d;
            size_err_q <= size_err_d;
        end
    end

    assign lambda_num   = lambda_q;
    assign finished_adj = finished_q;
    assign size_err     = size_err_q;

endmodule

// File: tb/tb_bch_adj_syndrome_mul.sv
// Randomised self-checking bench for bch_adj_syndrome_mul against a carry-less
// multiply plus long-division reference of the adjugate-times-syndrome vector.
module tb_bch_adj_syndrome_mul;
    import bch_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [3:0][3:0][WIDTH-1:0] minor_matrix;
    logic [3:0][GF_M-1:0]       syndrome_vec;
    logic [4:0]                 size;
    logic                       start_adj;
    logic [3:0][GF_M-1:0]       lambda_num;
    logic                       finished_adj;
    logic                       size_err;

    int tests = 0;
    int fails = 0;
    logic [3:0][GF_M-1:0] last_lam = '0;

    bch_adj_syndrome_mul dut (
        .clk          (clk),
        .rst          (rst),
        .minor_matrix (minor_matrix),
        .syndrome_vec (syndrome_vec),
        .size         (size),
        .start_adj    (start_adj),
        .lambda_num   (lambda_num),
        .finished_adj (finished_adj),
        .size_err     (size_err)
    );

    always #5 clk = ~clk;

    // Schoolbook polynomial product, then reduce by long division.
    function automatic logic [5:0] refMul(input logic [50:0] a, input logic [5:0] b);
        logic [56:0] prod;
        logic [56:0] poly;
        prod = '0;
        poly = 57'(7'b1000011);
        for (int k = 0; k < 51; k++) begin
            if (a[k]) prod = prod ^ (57'(b) << k);
        end
        for (int bt = 56; bt >= 6; bt--) begin
            if (prod[bt]) prod = prod ^ (poly << (bt - 6));
        end
        return prod[5:0];
    endfunction

    function automatic logic [3:0][5:0] refAdj(input logic [3:0][3:0][50:0] mm,
                                               input logic [3:0][5:0] s, input int n);
        logic [3:0][5:0] res;
        res = '0;
        if (n == 2 || n == 3) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    res[i] = res[i] ^ refMul(mm[j][i], s[j]);
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the request and count edges (including the sampling edge) to completion.
    task automatic applyStimulus(output int lat);
        @(negedge clk);
        start_adj = 1'b1;
        lat = 0;
        while (finished_adj !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseStart(input string tag);
        @(negedge clk);
        start_adj = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_fin_low"}, 64'(finished_adj), 64'd0);
    endtask

    task automatic runCase(input string tag, input int n, input logic [3:0][3:0][50:0] mm,
                           input logic [3:0][5:0] s, input logic do_release);
        logic [3:0][5:0] exp_lam;
        int exp_lat;
        int lat;
        minor_matrix = mm;
        syndrome_vec = s;
        size         = 5'(n);
        exp_lam = refAdj(mm, s, n);
        exp_lat = (n == 2 || n == 3) ? 53 * n * n + 2 : 2;
        applyStimulus(lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_lam"}, 64'(lambda_num), 64'(exp_lam));
        checkOutput({tag, "_err"}, 64'(size_err), 64'((n == 2 || n == 3) ? 0 : 1));
        last_lam = exp_lam;
        if (do_release) releaseStart(tag);
    endtask

    task automatic randomInputs(output logic [3:0][3:0][50:0] mm, output logic [3:0][5:0] s);
        for (int j = 0; j < 4; j++) begin
            s[j] = gf_elem_t'($urandom());
            for (int i = 0; i < 4; i++) mm[j][i] = wide_elem_t'({$urandom(), $urandom()});
        end
    endtask

    initial begin
        logic [3:0][3:0][50:0] mm;
        logic [3:0][5:0] s;
        int bad;
        int seen;

        rst = 1'b1;
        start_adj = 1'b0;
        minor_matrix = '0;
        syndrome_vec = '0;
        size = 5'd2;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_lam", 64'(lambda_num), 64'd0);
        checkOutput("rst_fin", 64'(finished_adj), 64'd0);
        checkOutput("rst_err", 64'(size_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        mm = '0; s = '0;
        mm[0][0] = 51'd1; mm[1][1] = 51'd1; s[0] = 6'd5; s[1] = 6'd9;
        runCase("ident", 2, mm, s, 1'b1);
        checkOutput("ident_const", 64'(lambda_num), 64'({6'd0, 6'd0, 6'd9, 6'd5}));

        mm = '0; s = '0;
        mm[0][0] = 51'h40; s[0] = 6'd1; s[1] = 6'd7;
        runCase("red40", 2, mm, s, 1'b1);
        checkOutput("red40_const", 64'(lambda_num[0]), 64'd3);
        mm[0][0] = 51'd32; s[0] = 6'd2;
        runCase("red32", 2, mm, s, 1'b1);

        mm = '0; s = '0;
        mm[1][0] = 51'd2; mm[2][0] = 51'd3; s[1] = 6'd4; s[2] = 6'd5;
        runCase("xpose", 3, mm, s, 1'b1);
        checkOutput("xpose_const", 64'(lambda_num), 64'd7);

        // Handshake: hold the request after completion, then re-raise.
        randomInputs(mm, s);
        runCase("hold", 2, mm, s, 1'b0);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (finished_adj !== 1'b1 || lambda_num !== last_lam) bad++;
        end
        checkOutput("hold_stable", 64'(bad), 64'd0);
        releaseStart("hold");
        runCase("rerun", 2, mm, s, 1'b1);

        // Abort a size-3 run part way through.
        randomInputs(mm, s);
        minor_matrix = mm;
        syndrome_vec = s;
        size = 5'd3;
        @(negedge clk);
        start_adj = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        start_adj = 1'b0;
        seen = 0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (finished_adj === 1'b1) seen++;
        end
        checkOutput("abort_fin", 64'(seen), 64'd0);
        checkOutput("abort_lam", 64'(lambda_num), 64'(last_lam));

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start_adj = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("amid_lam", 64'(lambda_num), 64'd0);
        checkOutput("amid_fin", 64'(finished_adj), 64'd0);
        checkOutput("amid_err", 64'(size_err), 64'd0);
        @(negedge clk);
        start_adj = 1'b0;
        rst = 1'b0;
        runCase("after_rst", 3, mm, s, 1'b1);

        randomInputs(mm, s);
        runCase("bad4", 4, mm, s, 1'b1);
        runCase("bad1", 1, mm, s, 1'b1);

        for (int t = 0; t < 8; t++) begin
            randomInputs(mm, s);
            runCase($sformatf("rand%0d", t), (($urandom() & 1) != 0) ? 3 : 2, mm, s, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
